// File: rtl/sap1_pkg.sv
// SAP-1 shared constants: opcodes, control-word bit positions, fixed control words.
package sap1_pkg;

  localparam int OP_W = 4;
  localparam int CW_W = 12;

  // Opcodes (IR upper nibble)
  localparam logic [OP_W-1:0] OP_LDA = 4'b0000;
  localparam logic [OP_W-1:0] OP_ADD = 4'b0001;
  localparam logic [OP_W-1:0] OP_SUB = 4'b0010;
  localparam logic [OP_W-1:0] OP_OUT = 4'b1110;
  localparam logic [OP_W-1:0] OP_HLT = 4'b1111;

  // Control word bit positions, MSB first: {Cp,Ep,nLm,nCE,nLi,nEi,nLa,Ea,Su,Eu,nLb,nLo}
  localparam int CON_CP  = 11;
  localparam int CON_EP  = 10;
  localparam int CON_NLM = 9;
  localparam int CON_NCE = 8;
  localparam int CON_NLI = 7;
  localparam int CON_NEI = 6;
  localparam int CON_NLA = 5;
  localparam int CON_EA  = 4;
  localparam int CON_SU  = 3;
  localparam int CON_EU  = 2;
  localparam int CON_NLB = 1;
  localparam int CON_NLO = 0;

  // Idle word: every active-low load/enable deasserted, every active-high one off
  localparam logic [CW_W-1:0] CW_IDLE     = 12'h3E3;
  localparam logic [CW_W-1:0] CW_FETCH_T1 = 12'h5E3;  // Ep, nLm
  localparam logic [CW_W-1:0] CW_FETCH_T2 = 12'hBE3;  // Cp
  localparam logic [CW_W-1:0] CW_FETCH_T3 = 12'h263;  // nCE, nLi

endpackage

// File: rtl/sap1_ring_counter.sv
// One-hot T-state ring counter; async CLR returns to T1.
module sap1_ring_counter #(
  parameter int N = 6
) (
  input  logic         clk,
  input  logic         CLR,
  input  logic         en,
  output logic [N-1:0] q
);

  // Rotate the single hot bit one place per enable; top state wraps to T1
  always_ff @(posedge clk or posedge CLR) begin
    if (CLR)     q <= N'(1);
    else if (en) q <= {q[N-2:0], q[N-1]};
  end

endmodule

// File: rtl/sap1_control_sequencer.sv
// SAP-1 controller-sequencer: T-state ring, opcode decode to the 12-bit
// control word, and the halt latch that stops the clock generator.
module sap1_control_sequencer
  import sap1_pkg::*;
#(
  parameter int T_STATES = 6,
  parameter int OP_W     = 4
) (
  input  logic            clk,
  input  logic            CLR,
  input  logic            clk_en,
  input  logic            run,
  input  logic [OP_W-1:0] opcode,
  output logic [11:0]     con,
  output logic            nHLT,
  output logic [5:0]      tstate
);

  logic [T_STATES-1:0] ring;
  logic                adv;
  logic [11:0]         cw;

  // Halted or programming mode freezes the ring
  assign adv = clk_en & run & nHLT;

  sap1_ring_counter #(.N(T_STATES)) u_ring (
    .clk (clk),
    .CLR (CLR),
    .en  (adv),
    .q   (ring)
  );

  // Zero-extend the ring to the fixed 6-bit LED bus; unused states stay dark
  always_comb begin
    tstate                 = '0;
    tstate[T_STATES-1:0]   = ring;
  end

  // HLT is caught on the edge that leaves T3, so T4 is already halted
  always_ff @(posedge clk or posedge CLR) begin
    if (CLR)                                      nHLT <= 1'b1;
    else if (adv && tstate[2] && opcode == OP_HLT) nHLT <= 1'b0;
  end

  // Microcode lookup; states past T_STATES never light, so their slots drop out
  always_comb begin
    cw = CW_IDLE;
    casez ({tstate, opcode})
      {6'b000001, 4'b????}: cw = CW_FETCH_T1;
      {6'b000010, 4'b????}: cw = CW_FETCH_T2;
      {6'b000100, 4'b????}: cw = CW_FETCH_T3;
      {6'b001000, OP_LDA}:  cw = 12'h1A3;
      {6'b010000, OP_LDA}:  cw = 12'h2C3;
      {6'b001000, OP_ADD}:  cw = 12'h1A3;
      {6'b010000, OP_ADD}:  cw = 12'h2E1;
      {6'b100000, OP_ADD}:  cw = 12'h3C7;
      {6'b001000, OP_SUB}:  cw = 12'h1A3;
      {6'b010000, OP_SUB}:  cw = 12'h2E1;
      {6'b100000, OP_SUB}:  cw = 12'h3CF;
      {6'b001000, OP_OUT}:  cw = 12'h3F2;
      default:              cw = CW_IDLE;
    endcase
  end

  // Bus ownership gate: manual mode or halt parks every control line
  always_comb begin
    con = cw;
    if (!run || !nHLT) con = CW_IDLE;
  end

endmodule

// File: tb/tb_sap1_control_sequencer.sv
// Directed bench for the SAP-1 controller-sequencer (6-state and 4-state rings).
module tb_sap1_control_sequencer;

  logic        clk = 1'b0;
  logic        CLR;
  logic        clk_en;
  logic        run;
  logic [3:0]  opcode;
  logic [11:0] con, con4;
  logic        nHLT, nHLT4;
  logic [5:0]  tstate, tstate4;

  int n_pass = 0;
  int n_tot  = 0;

  always #5 clk = ~clk;

  sap1_control_sequencer #(.T_STATES(6)) dut (
    .clk(clk), .CLR(CLR), .clk_en(clk_en), .run(run), .opcode(opcode),
    .con(con), .nHLT(nHLT), .tstate(tstate)
  );

  sap1_control_sequencer #(.T_STATES(4)) dut4 (
    .clk(clk), .CLR(CLR), .clk_en(clk_en), .run(run), .opcode(opcode),
    .con(con4), .nHLT(nHLT4), .tstate(tstate4)
  );

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    n_tot++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %03h want %03h", tag, obs, exp);
  endtask

  // One-cycle advance strobe; returns on the negedge after the capturing posedge
  task automatic pulse();
    @(negedge clk); clk_en = 1'b1;
    @(negedge clk); clk_en = 1'b0;
  endtask

  task automatic do_clr();
    @(negedge clk); CLR = 1'b1;
    @(negedge clk); CLR = 1'b0;
  endtask

  logic [11:0] add_seq [7] = '{12'h5E3, 12'hBE3, 12'h263, 12'h1A3, 12'h2E1, 12'h3C7, 12'h5E3};
  logic [11:0] sub4_seq[5] = '{12'h5E3, 12'hBE3, 12'h263, 12'h1A3, 12'h5E3};

  initial begin
    CLR = 1'b1; clk_en = 1'b0; run = 1'b1; opcode = 4'b0001;

    // 1. reset state
    @(negedge clk);
    chk("rst_tstate", 12'(tstate), 12'h001);
    chk("rst_con_run", con, 12'h5E3);
    chk("rst_nhlt", 12'(nHLT), 12'h1);
    run = 1'b0; #1;
    chk("rst_con_norun", con, 12'h3E3);
    run = 1'b1;
    @(negedge clk); CLR = 1'b0;

    // 2. ADD full ring and wrap
    chk("add_t1", con, add_seq[0]);
    for (int i = 1; i < 7; i++) begin
      pulse();
      chk($sformatf("add_step%0d", i), con, add_seq[i]);
    end
    chk("add_wrap_t", 12'(tstate), 12'h001);

    // 3. HLT
    do_clr(); opcode = 4'b1111;
    repeat (3) pulse();
    chk("hlt_nhlt", 12'(nHLT), 12'h0);
    chk("hlt_t4", 12'(tstate), 12'h008);
    chk("hlt_con", con, 12'h3E3);
    repeat (10) pulse();
    chk("hlt_frozen", 12'(tstate), 12'h008);
    chk("hlt_still", 12'(nHLT), 12'h0);
    do_clr();
    chk("hlt_clr_t", 12'(tstate), 12'h001);
    chk("hlt_clr_n", 12'(nHLT), 12'h1);

    // 4. LDA with run dropped at T5
    opcode = 4'b0000;
    repeat (3) pulse();
    chk("lda_t4", con, 12'h1A3);
    pulse();
    chk("lda_t5", con, 12'h2C3);
    run = 1'b0;
    repeat (20) pulse();
    chk("lda_hold_t", 12'(tstate), 12'h010);
    chk("lda_hold_con", con, 12'h3E3);
    run = 1'b1; #1;
    chk("lda_resume", con, 12'h2C3);
    pulse();
    chk("lda_t6", con, 12'h3E3);
    chk("lda_t6_t", 12'(tstate), 12'h020);

    // 5. CLR beats clk_en in T3; undefined opcode is NOP
    do_clr(); opcode = 4'b0101;
    repeat (2) pulse();
    chk("clr_pre_t3", 12'(tstate), 12'h004);
    @(negedge clk); CLR = 1'b1; clk_en = 1'b1;
    @(negedge clk); CLR = 1'b0; clk_en = 1'b0;
    chk("clr_win_t", 12'(tstate), 12'h001);
    repeat (3) pulse();
    chk("nop_t4", con, 12'h3E3);
    pulse();
    chk("nop_t5", con, 12'h3E3);
    pulse();
    chk("nop_t6", con, 12'h3E3);
    chk("nop_t6_t", 12'(tstate), 12'h020);
    pulse();
    chk("nop_wrap", con, 12'h5E3);

    // 6. SUB on both rings; 4-state ring truncates after T4
    do_clr(); opcode = 4'b0010;
    chk("sub4_0", con4, sub4_seq[0]);
    for (int i = 1; i < 5; i++) begin
      pulse();
      chk($sformatf("sub4_%0d", i), con4, sub4_seq[i]);
      if (i == 4) chk("sub6_t5", con, 12'h2E1);
    end
    chk("sub4_wrap_t", 12'(tstate4), 12'h001);
    pulse();
    chk("sub6_t6", con, 12'h3CF);

    // OUT word at T4
    do_clr(); opcode = 4'b1110;
    repeat (3) pulse();
    chk("out_t4", con, 12'h3F2);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
